// File: rtl/amo_responder_pkg.sv
// Shared types and constants for the AMO responder slice: request/response
// structs, operation encoding and a couple of write-path helpers.
package amo_responder_pkg;

    localparam int DataWidth            = 64;
    localparam int AddrWidth            = 56;
    localparam int AMO_RES_GRANULE_BITS = 3;
    localparam int GranuleWidth         = AddrWidth - AMO_RES_GRANULE_BITS;

    localparam logic [1:0] SizeWord   = 2'b10;
    localparam logic [1:0] SizeDouble = 2'b11;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_LR   = 4'd1,
        AMO_SC   = 4'd2,
        AMO_SWAP = 4'd3,
        AMO_ADD  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_XOR  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MAXU = 4'd9,
        AMO_MIN  = 4'd10,
        AMO_MINU = 4'd11
    } amo_t;

    typedef struct packed {
        logic                 req;
        amo_t                 amo_op;
        logic [1:0]           size;
        logic [DataWidth-1:0] operand_a;
        logic [DataWidth-1:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic                 ack;
        logic [DataWidth-1:0] result;
    } amo_resp_t;

    // Word data goes out in both halves so the byte enables alone pick the lane.
    function automatic logic [DataWidth-1:0] packWriteData(input logic isDouble,
                                                            input logic [DataWidth-1:0] value);
        return isDouble ? value : {value[31:0], value[31:0]};
    endfunction

    function automatic logic [7:0] byteEnable(input logic isDouble, input logic upperWord);
        if (isDouble) return 8'hFF;
        return upperWord ? 8'hF0 : 8'h0F;
    endfunction

endpackage

// File: rtl/amo_responder_if.sv
// Single-ported memory request bus between the AMO responder (master) and
// the LLC / scratchpad (slave). Writes complete on grant; reads return rdata
// with rvalid some cycles after the grant.
interface amo_responder_if;
    import amo_responder_pkg::*;

    logic                 mem_req;
    logic                 mem_gnt;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_wdata;
    logic [7:0]           mem_be;
    logic                 mem_rvalid;
    logic [DataWidth-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/amo_responder_alu.sv
// Combinational modify step of the read-modify-write. For word operations
// only the low 32 bits of the result are meaningful; the caller replicates them.
module amo_alu
    import amo_responder_pkg::*;
(
    input  amo_t                 op_i,
    input  logic                 isDouble_i,
    input  logic [DataWidth-1:0] old_i,
    input  logic [DataWidth-1:0] operand_i,
    output logic [DataWidth-1:0] new_o
);

    logic lessSigned;
    logic lessUnsigned;

    // Compare old against operand at the operation size, signed and unsigned.
    always_comb begin
        if (isDouble_i) begin
            lessSigned   = $signed(old_i) < $signed(operand_i);
            lessUnsigned = old_i < operand_i;
        end else begin
            lessSigned   = $signed(old_i[31:0]) < $signed(operand_i[31:0]);
            lessUnsigned = old_i[31:0] < operand_i[31:0];
        end
    end

    // Select the new memory value; all ops are lane-local so the low word is correct for word size.
    always_comb begin
        new_o = operand_i;
        case (op_i)
            AMO_SWAP: new_o = operand_i;
            AMO_ADD:  new_o = old_i + operand_i;
            AMO_AND:  new_o = old_i & operand_i;
            AMO_OR:   new_o = old_i | operand_i;
            AMO_XOR:  new_o = old_i ^ operand_i;
            AMO_MAX:  new_o = lessSigned   ? operand_i : old_i;
            AMO_MAXU: new_o = lessUnsigned ? operand_i : old_i;
            AMO_MIN:  new_o = lessSigned   ? old_i : operand_i;
            AMO_MINU: new_o = lessUnsigned ? old_i : operand_i;
            default:  new_o = operand_i;
        endcase
    end

endmodule

// File: rtl/amo_responder.sv
// Memory-side executor for atomic memory operations. Takes one request at a
// time, runs the read-modify-write on the memory bus, tracks the LR/SC
// reservation and pulses ack with the result. Every output is decoded from
// registers only.
module amo_responder
    import amo_responder_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  amo_req_t             amo_req_i,
    output amo_resp_t            amo_resp_o,
    amo_responder_if.master      mem_if,
    input  logic                 inval_valid_i,
    input  logic [AddrWidth-1:0] inval_addr_i
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdReq  = 3'd1;
    localparam logic [2:0] StRdWait = 3'd2;
    localparam logic [2:0] StWrReq  = 3'd3;
    localparam logic [2:0] StResp   = 3'd4;

    logic [2:0]              state_q,      state_d;
    amo_t                    op_q,         op_d;
    logic                    isDouble_q,   isDouble_d;
    logic                    upperWord_q,  upperWord_d;
    logic [GranuleWidth-1:0] reqGranule_q, reqGranule_d;
    logic [DataWidth-1:0]    operandB_q,   operandB_d;
    logic [DataWidth-1:0]    result_q,     result_d;
    logic [DataWidth-1:0]    wdata_q,      wdata_d;
    logic [7:0]              be_q,         be_d;
    logic                    resValid_q,   resValid_d;
    logic [GranuleWidth-1:0] resGranule_q, resGranule_d;

    logic                    acceptReq;
    logic                    reqIsDouble;
    logic [GranuleWidth-1:0] inGranule;
    logic [31:0]             readWord;
    logic [DataWidth-1:0]    oldValue;
    logic [DataWidth-1:0]    newValue;
    logic                    unusedBits;

    assign acceptReq   = (state_q == StIdle) && amo_req_i.req && (amo_req_i.amo_op != AMO_NONE);
    assign reqIsDouble = (amo_req_i.size == SizeDouble);
    assign inGranule   = amo_req_i.operand_a[AddrWidth-1:AMO_RES_GRANULE_BITS];

    assign readWord = upperWord_q ? mem_if.mem_rdata[63:32] : mem_if.mem_rdata[31:0];
    assign oldValue = isDouble_q ? mem_if.mem_rdata : {{32{readWord[31]}}, readWord};

    assign unusedBits = ^{amo_req_i.operand_a[DataWidth-1:AddrWidth],
                          amo_req_i.operand_a[1:0], inval_addr_i[2:0]};

    amo_alu u_alu (
        .op_i       (op_q),
        .isDouble_i (isDouble_q),
        .old_i      (oldValue),
        .operand_i  (operandB_q),
        .new_o      (newValue)
    );

    // Operation sequencing: accept, read, modify, write, respond.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        isDouble_d   = isDouble_q;
        upperWord_d  = upperWord_q;
        reqGranule_d = reqGranule_q;
        operandB_d   = operandB_q;
        result_d     = result_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        case (state_q)
            StIdle: begin
                if (acceptReq) begin
                    op_d         = amo_req_i.amo_op;
                    isDouble_d   = reqIsDouble;
                    upperWord_d  = amo_req_i.operand_a[2];
                    reqGranule_d = inGranule;
                    operandB_d   = amo_req_i.operand_b;
                    be_d         = byteEnable(reqIsDouble, amo_req_i.operand_a[2]);
                    if (amo_req_i.amo_op == AMO_SC) begin
                        if (resValid_q && (resGranule_q == inGranule)) begin
                            wdata_d = packWriteData(reqIsDouble, amo_req_i.operand_b);
                            state_d = StWrReq;
                        end else begin
                            result_d = 64'd1;
                            state_d  = StResp;
                        end
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end
            StRdReq: begin
                if (mem_if.mem_gnt) state_d = StRdWait;
            end
            StRdWait: begin
                if (mem_if.mem_rvalid) begin
                    result_d = oldValue;
                    if (op_q == AMO_LR) begin
                        state_d = StResp;
                    end else begin
                        wdata_d = packWriteData(isDouble_q, newValue);
                        state_d = StWrReq;
                    end
                end
            end
            StWrReq: begin
                if (mem_if.mem_gnt) begin
                    if (op_q == AMO_SC) result_d = 64'd0;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reservation tracking; an invalidation of the granule always has the last word.
    always_comb begin
        resValid_d   = resValid_q;
        resGranule_d = resGranule_q;
        if (acceptReq && (amo_req_i.amo_op == AMO_SC)) begin
            resValid_d = 1'b0;
        end
        if ((state_q == StRdWait) && mem_if.mem_rvalid && (op_q == AMO_LR)) begin
            resValid_d   = 1'b1;
            resGranule_d = reqGranule_q;
        end
        if ((state_q == StWrReq) && mem_if.mem_gnt && (reqGranule_q == resGranule_q)) begin
            resValid_d = 1'b0;
        end
        if (inval_valid_i && (inval_addr_i[AddrWidth-1:AMO_RES_GRANULE_BITS] == resGranule_d)) begin
            resValid_d = 1'b0;
        end
    end

    // State and datapath registers; reset abandons any outstanding transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            op_q         <= AMO_NONE;
            isDouble_q   <= 1'b0;
            upperWord_q  <= 1'b0;
            reqGranule_q <= '0;
            operandB_q   <= '0;
            result_q     <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resValid_q   <= 1'b0;
            resGranule_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            isDouble_q   <= isDouble_d;
            upperWord_q  <= upperWord_d;
            reqGranule_q <= reqGranule_d;
            operandB_q   <= operandB_d;
            result_q     <= result_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resValid_q   <= resValid_d;
            resGranule_q <= resGranule_d;
        end
    end

    assign amo_resp_o.ack    = (state_q == StResp);
    assign amo_resp_o.result = result_q;

    assign mem_if.mem_req   = (state_q == StRdReq) || (state_q == StWrReq);
    assign mem_if.mem_we    = (state_q == StWrReq);
    assign mem_if.mem_addr  = {reqGranule_q, 3'b000};
    assign mem_if.mem_wdata = wdata_q;
    assign mem_if.mem_be    = be_q;

endmodule

// File: tb/tb_amo_responder.sv
// Directed bench for amo_responder: a vector table of single operations
// against a small memory model, plus hand-written LR/SC invalidation and
// mid-operation reset sequences.
module tb_amo_responder;
    import amo_responder_pkg::*;

    logic                 clock;
    logic                 reset;
    amo_req_t             amoReq;
    amo_resp_t            amoResp;
    logic                 invalValid;
    logic [AddrWidth-1:0] invalAddr;

    amo_responder_if memBus ();

    amo_responder dut (
        .clk_i         (clock),
        .rst_i         (reset),
        .amo_req_i     (amoReq),
        .amo_resp_o    (amoResp),
        .mem_if        (memBus),
        .inval_valid_i (invalValid),
        .inval_addr_i  (invalAddr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Memory model: 64 doublewords indexed by addr[8:3].
    logic [63:0] memArr [0:63];
    int          gntStallCfg = 0;
    int          rvStallCfg  = 0;
    int          gntLeft     = 0;
    int          rvLeft      = 0;
    bit          readPending = 0;
    int          readIdx     = 0;
    int          grantCount  = 0;

    // Drive grant and read data for the coming cycle.
    always @(negedge clock) begin
        memBus.mem_gnt    = 1'b0;
        memBus.mem_rvalid = 1'b0;
        if (readPending) begin
            if (rvLeft > 0) begin
                rvLeft = rvLeft - 1;
            end else begin
                memBus.mem_rvalid = 1'b1;
                memBus.mem_rdata  = memArr[readIdx];
                readPending       = 0;
            end
        end
        if (memBus.mem_req === 1'b1) begin
            if (gntLeft > 0) gntLeft = gntLeft - 1;
            else memBus.mem_gnt = 1'b1;
        end
    end

    // Commit granted transactions at the edge the responder samples the grant.
    always @(posedge clock) begin
        if (!reset && memBus.mem_req === 1'b1 && memBus.mem_gnt === 1'b1) begin
            grantCount = grantCount + 1;
            gntLeft    = gntStallCfg;
            if (memBus.mem_we) begin
                for (int k = 0; k < 8; k++)
                    if (memBus.mem_be[k])
                        memArr[memBus.mem_addr[8:3]][8*k +: 8] = memBus.mem_wdata[8*k +: 8];
            end else begin
                readPending = 1;
                readIdx     = int'(memBus.mem_addr[8:3]);
                rvLeft      = rvStallCfg;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ack"},    64'(amoResp.ack), 64'd0);
        checkOutput({tag, " result"}, amoResp.result, 64'd0);
        checkOutput({tag, " req/we/be"}, 64'({memBus.mem_req, memBus.mem_we, memBus.mem_be}), 64'd0);
        checkOutput({tag, " addr"},   64'(memBus.mem_addr), 64'd0);
        checkOutput({tag, " wdata"},  memBus.mem_wdata, 64'd0);
    endtask

    // Issue one operation at cycle 0 and watch the bus until ack or timeout.
    task automatic applyStimulus(input amo_t op, input logic [1:0] size, input logic [63:0] addr,
                                 input logic [63:0] b, input bit expWrite, input logic [63:0] expWdata,
                                 input logic [7:0] expBe, output int ackCyc, output logic [63:0] res,
                                 output int grants, output bit busOk);
        int startGrants;
        logic [AddrWidth-1:0] expAddr;
        expAddr = {addr[AddrWidth-1:3], 3'b000};
        @(negedge clock);
        startGrants      = grantCount;
        amoReq.req       = 1'b1;
        amoReq.amo_op    = op;
        amoReq.size      = size;
        amoReq.operand_a = addr;
        amoReq.operand_b = b;
        ackCyc = -1;
        res    = '0;
        busOk  = 1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (memBus.mem_req) begin
                if (memBus.mem_addr !== expAddr) busOk = 0;
                if (memBus.mem_we) begin
                    if (!expWrite || memBus.mem_wdata !== expWdata || memBus.mem_be !== expBe) busOk = 0;
                end
            end
            if (amoResp.ack) begin
                ackCyc = c;
                res    = amoResp.result;
                break;
            end
        end
        amoReq = '0;
        grants = grantCount - startGrants;
    endtask

    task automatic runAndCheck(input string name, input amo_t op, input logic [1:0] size,
                               input logic [63:0] addr, input logic [63:0] b, input bit expWrite,
                               input logic [63:0] expWdata, input logic [7:0] expBe,
                               input int expAck, input logic [63:0] expRes, input int expGrants);
        int ackCyc, grants;
        logic [63:0] res;
        bit busOk;
        applyStimulus(op, size, addr, b, expWrite, expWdata, expBe, ackCyc, res, grants, busOk);
        checkOutput({name, " ack cycle"}, 64'(ackCyc), 64'(expAck));
        checkOutput({name, " result"}, res, expRes);
        checkOutput({name, " grants"}, 64'(grants), 64'(expGrants));
        checkOutput({name, " bus"}, 64'(busOk), 64'd1);
    endtask

    typedef struct {
        amo_t        op;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] b;
        bit          preload;
        logic [63:0] preVal;
        int          gntStall;
        int          expAck;
        logic [63:0] expResult;
        int          expGrants;
        bit          expWrite;
        logic [63:0] expWdata;
        logic [7:0]  expBe;
        logic [63:0] expMem;
    } vec_t;

    vec_t vectors [18];

    initial begin
        reset      = 1'b1;
        amoReq     = '0;
        invalValid = 1'b0;
        invalAddr  = '0;
        memBus.mem_gnt    = 1'b0;
        memBus.mem_rvalid = 1'b0;
        memBus.mem_rdata  = '0;
        for (int i = 0; i < 64; i++) memArr[i] = '0;

        vectors[0]  = '{AMO_ADD,  SizeDouble, 64'h80,  64'd7,     1, 64'd5,                   0, 4,  64'd5,                   2, 1, 64'd12,                  8'hFF, 64'd12};
        vectors[1]  = '{AMO_MAX,  SizeWord,   64'h84,  64'd1,     1, 64'hFFFFFFFF_12345678,   0, 4,  64'hFFFFFFFF_FFFFFFFF,   2, 1, 64'h00000001_00000001,   8'hF0, 64'h00000001_12345678};
        vectors[2]  = '{AMO_MAXU, SizeWord,   64'h84,  64'd1,     1, 64'hFFFFFFFF_12345678,   0, 4,  64'hFFFFFFFF_FFFFFFFF,   2, 1, 64'hFFFFFFFF_FFFFFFFF,   8'hF0, 64'hFFFFFFFF_12345678};
        vectors[3]  = '{AMO_MIN,  SizeWord,   64'h80,  64'd5,     1, 64'h00000000_80000000,   0, 4,  64'hFFFFFFFF_80000000,   2, 1, 64'h80000000_80000000,   8'h0F, 64'h00000000_80000000};
        vectors[4]  = '{AMO_ADD,  SizeWord,   64'h90,  64'd2,     1, 64'hAAAAAAAA_FFFFFFFF,   0, 4,  64'hFFFFFFFF_FFFFFFFF,   2, 1, 64'h00000001_00000001,   8'h0F, 64'hAAAAAAAA_00000001};
        vectors[5]  = '{AMO_AND,  SizeDouble, 64'h88,  64'hFF00,  1, 64'hF0F0,                0, 4,  64'hF0F0,                2, 1, 64'hF000,                8'hFF, 64'hF000};
        vectors[6]  = '{AMO_OR,   SizeDouble, 64'h98,  64'h0F,    1, 64'hF0,                  0, 4,  64'hF0,                  2, 1, 64'hFF,                  8'hFF, 64'hFF};
        vectors[7]  = '{AMO_XOR,  SizeDouble, 64'hA0,  64'hFF,    1, 64'h0F,                  0, 4,  64'h0F,                  2, 1, 64'hF0,                  8'hFF, 64'hF0};
        vectors[8]  = '{AMO_MINU, SizeDouble, 64'hA8,  64'd2,     1, 64'hFFFFFFFF_FFFFFFFE,   0, 4,  64'hFFFFFFFF_FFFFFFFE,   2, 1, 64'd2,                   8'hFF, 64'd2};
        vectors[9]  = '{AMO_MAX,  SizeDouble, 64'hB8,  64'd3,     1, 64'hFFFFFFFF_FFFFFFFB,   0, 4,  64'hFFFFFFFF_FFFFFFFB,   2, 1, 64'd3,                   8'hFF, 64'd3};
        vectors[10] = '{AMO_SWAP, SizeDouble, 64'hC0,  64'hDEAD,  1, 64'd3,                   0, 4,  64'd3,                   2, 1, 64'hDEAD,                8'hFF, 64'hDEAD};
        vectors[11] = '{AMO_ADD,  SizeDouble, 64'hC8,  64'd2,     1, 64'hFFFFFFFF_FFFFFFFF,   0, 4,  64'hFFFFFFFF_FFFFFFFF,   2, 1, 64'd1,                   8'hFF, 64'd1};
        vectors[12] = '{AMO_ADD,  SizeDouble, 64'h80,  64'd7,     1, 64'd5,                   3, 10, 64'd5,                   2, 1, 64'd12,                  8'hFF, 64'd12};
        vectors[13] = '{AMO_LR,   SizeDouble, 64'h100, 64'd0,     1, 64'h55,                  0, 3,  64'h55,                  1, 0, 64'd0,                   8'h00, 64'h55};
        vectors[14] = '{AMO_SC,   SizeDouble, 64'h100, 64'd9,     0, 64'd0,                   0, 2,  64'd0,                   1, 1, 64'd9,                   8'hFF, 64'd9};
        vectors[15] = '{AMO_SC,   SizeDouble, 64'h100, 64'd10,    0, 64'd0,                   0, 1,  64'd1,                   0, 0, 64'd0,                   8'h00, 64'd9};
        vectors[16] = '{AMO_LR,   SizeWord,   64'h104, 64'd0,     1, 64'h80000001_00000000,   0, 3,  64'hFFFFFFFF_80000001,   1, 0, 64'd0,                   8'h00, 64'h80000001_00000000};
        vectors[17] = '{AMO_SC,   SizeWord,   64'h104, 64'h22,    0, 64'd0,                   0, 2,  64'd0,                   1, 1, 64'h00000022_00000022,   8'hF0, 64'h00000022_00000000};

        #12;
        checkResetOutputs("reset");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (vectors[i].preload) memArr[vectors[i].addr[8:3]] = vectors[i].preVal;
            gntStallCfg = vectors[i].gntStall;
            gntLeft     = vectors[i].gntStall;
            runAndCheck($sformatf("v%0d", i), vectors[i].op, vectors[i].size, vectors[i].addr,
                        vectors[i].b, vectors[i].expWrite, vectors[i].expWdata, vectors[i].expBe,
                        vectors[i].expAck, vectors[i].expResult, vectors[i].expGrants);
            checkOutput($sformatf("v%0d mem", i), memArr[vectors[i].addr[8:3]], vectors[i].expMem);
        end
        gntStallCfg = 0;
        gntLeft     = 0;

        // Invalidation of the reserved granule through a different byte address kills the SC.
        runAndCheck("lrA", AMO_LR, SizeDouble, 64'h100, 64'd0, 0, 64'd0, 8'h00, 3, 64'h00000022_00000000, 1);
        @(negedge clock);
        invalValid = 1'b1;
        invalAddr  = 56'h104;
        @(negedge clock);
        invalValid = 1'b0;
        runAndCheck("scA", AMO_SC, SizeDouble, 64'h100, 64'd1, 0, 64'd0, 8'h00, 1, 64'd1, 0);

        // Invalidation of the neighbouring granule leaves the reservation intact.
        runAndCheck("lrB", AMO_LR, SizeDouble, 64'h100, 64'd0, 0, 64'd0, 8'h00, 3, 64'h00000022_00000000, 1);
        @(negedge clock);
        invalValid = 1'b1;
        invalAddr  = 56'h108;
        @(negedge clock);
        invalValid = 1'b0;
        runAndCheck("scB", AMO_SC, SizeDouble, 64'h100, 64'h77, 1, 64'h77, 8'hFF, 2, 64'd0, 1);
        checkOutput("scB mem", memArr[32], 64'h77);

        // Invalidation landing in the same cycle the LR captures its data wins.
        fork
            runAndCheck("lrC", AMO_LR, SizeDouble, 64'h100, 64'd0, 0, 64'd0, 8'h00, 3, 64'h77, 1);
            begin
                repeat (3) @(negedge clock);
                invalValid = 1'b1;
                invalAddr  = 56'h100;
                @(negedge clock);
                invalValid = 1'b0;
            end
        join
        runAndCheck("scC", AMO_SC, SizeDouble, 64'h100, 64'h99, 0, 64'd0, 8'h00, 1, 64'd1, 0);

        // Reset while waiting for read data: outputs clear at once, late rvalid ignored, reservation gone.
        runAndCheck("lrD", AMO_LR, SizeDouble, 64'h100, 64'd0, 0, 64'd0, 8'h00, 3, 64'h77, 1);
        memArr[22] = 64'h40;
        rvStallCfg = 3;
        @(negedge clock);
        amoReq.req       = 1'b1;
        amoReq.amo_op    = AMO_ADD;
        amoReq.size      = SizeDouble;
        amoReq.operand_a = 64'hB0;
        amoReq.operand_b = 64'd1;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 checkResetOutputs("midReset");
        amoReq = '0;
        @(negedge clock);
        reset = 1'b0;
        begin
            bit quiet;
            quiet = 1;
            repeat (6) begin
                @(negedge clock);
                if (memBus.mem_req !== 1'b0 || amoResp.ack !== 1'b0) quiet = 0;
            end
            checkOutput("postReset quiet", 64'(quiet), 64'd1);
        end
        checkOutput("postReset mem", memArr[22], 64'h40);
        rvStallCfg = 0;
        runAndCheck("scD", AMO_SC, SizeDouble, 64'h100, 64'h55, 0, 64'd0, 8'h00, 1, 64'd1, 0);
        checkOutput("scD mem", memArr[32], 64'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
